led_blink_bank: RTL

- Multi-channel, run-time configurable successor to the single fixed-rate LED blinker.
- A shared prescaler produces a slow tick.
- Each of CHANNELS independent channels drives one LED in OFF, ON, BLINK or ONESHOT mode, with programmable period and on-time measured in ticks.
- Sits at board top level between a simple register/config source and the LED pins.

---
 rtl/led_blink_pkg.sv | 18 +
 rtl/led_blink_chan.sv | 100 ++++++++++
 rtl/led_blink_bank.sv | 100 ++++++++++
 3 files changed

// File: rtl/led_blink_pkg.sv
// rtl/led_blink_pkg.sv - shared types and helpers for the LED blink bank.
package led_blink_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_ONESHOT = 2'd3
   } blink_mode_t;

   localparam int PWM_W = 8;

   // Index width that stays at least one bit wide for a single channel.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/led_blink_chan.sv
// rtl/led_blink_chan.sv - one LED channel: config registers, tick-driven phase and mode FSM.
// LED_BLINK_BANK_PWM_EN adds a per-channel brightness register.
module led_blink_chan
   import led_blink_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int DEF_PERIOD = 1000,
   parameter int DEF_ON     = 500,
   parameter int DEF_MODE   = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [1:0]       mode_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic [CNT_W-1:0] on_i,
`ifdef LED_BLINK_BANK_PWM_EN
   input  logic [PWM_W-1:0] bright_i,
   output logic [PWM_W-1:0] bright_o,
`endif
   input  logic             sync_i,
   input  logic             tick_i,
   output logic             state_o,
   output logic             busy_o
);

   blink_mode_t      mode_q, mode_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] on_q, on_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0] last_phase;
   logic             lit;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q   <= blink_mode_t'(2'(DEF_MODE));
         period_q <= CNT_W'(DEF_PERIOD);
         on_q     <= CNT_W'(DEF_ON);
         phase_q  <= '0;
      end else begin
         mode_q   <= mode_d;
         period_q <= period_d;
         on_q     <= on_d;
         phase_q  <= phase_d;
      end
   end

   // A zero period behaves as a period of one tick.
   assign last_phase = (period_q == '0) ? '0 : period_q - CNT_W'(1);

   always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      on_d     = on_q;
      phase_d  = phase_q;
      if (we_i) begin
         mode_d   = blink_mode_t'(mode_i);
         period_d = period_i;
         on_d     = on_i;
         phase_d  = '0;
      end else begin
         if (mode_q == MODE_ONESHOT && !lit) begin
            mode_d = MODE_OFF;
         end
         if (sync_i) begin
            phase_d = '0;
         end else if (tick_i) begin
            if (mode_q == MODE_ONESHOT) begin
               if (lit) phase_d = phase_q + CNT_W'(1);
            end else begin
               phase_d = (phase_q >= last_phase) ? '0 : phase_q + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      lit = 1'b0;
      case (mode_q)
         MODE_ON:                  lit = 1'b1;
         MODE_BLINK, MODE_ONESHOT: lit = (phase_q < on_q);
         default:                  lit = 1'b0;
      endcase
   end

   assign state_o = lit;
   assign busy_o  = (mode_q == MODE_ONESHOT) && lit;

`ifdef LED_BLINK_BANK_PWM_EN
   logic [PWM_W-1:0] bright_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)     bright_q <= '1;
      else if (we_i) bright_q <= bright_i;
   end

   assign bright_o = bright_q;
`endif

endmodule

// File: rtl/led_blink_bank.sv
// rtl/led_blink_bank.sv - multi-channel LED blinker with shared tick prescaler.
// LED_BLINK_BANK_PWM_EN adds a cfg_bright input and a shared PWM dimming counter.
module led_blink_bank
   import led_blink_pkg::*;
#(
   parameter int  CLK_HZ     = 50000000,
   parameter int  TICK_HZ    = 1000,
   parameter int  CHANNELS   = 4,
   parameter int  CNT_W      = 16,
   parameter int  DEF_PERIOD = 1000,
   parameter int  DEF_ON     = 500,
   parameter int  DEF_MODE   = 2,
   localparam int CH_W       = clog2_min1(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [CNT_W-1:0]    cfg_period,
   input  logic [CNT_W-1:0]    cfg_on,
`ifdef LED_BLINK_BANK_PWM_EN
   input  logic [PWM_W-1:0]    cfg_bright,
`endif
   input  logic                sync,
   output logic                tick,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] led
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PRE_W = clog2_min1(DIV);

   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [CHANNELS-1:0] state;
   logic [CHANNELS-1:0] led_q, led_d;

   assign tick  = (pre_q == PRE_W'(DIV - 1));
   assign pre_d = (sync || tick) ? '0 : pre_q + PRE_W'(1);

   always_ff @(posedge clk) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
   end

`ifdef LED_BLINK_BANK_PWM_EN
   logic [PWM_W-1:0] pwm_q;
   logic [PWM_W-1:0] bright [CHANNELS];

   always_ff @(posedge clk) begin
      if (rst) pwm_q <= '0;
      else     pwm_q <= pwm_q + PWM_W'(1);
   end
`endif

   // A channel index match implies cfg_ch < CHANNELS, so out-of-range writes fall through.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic ch_we;
      assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

      led_blink_chan #(
         .CNT_W      (CNT_W),
         .DEF_PERIOD (DEF_PERIOD),
         .DEF_ON     (DEF_ON),
         .DEF_MODE   (DEF_MODE)
      ) u_chan (
         .clk_i    (clk),
         .rst_i    (rst),
         .we_i     (ch_we),
         .mode_i   (cfg_mode),
         .period_i (cfg_period),
         .on_i     (cfg_on),
`ifdef LED_BLINK_BANK_PWM_EN
         .bright_i (cfg_bright),
         .bright_o (bright[i]),
`endif
         .sync_i   (sync),
         .tick_i   (tick),
         .state_o  (state[i]),
         .busy_o   (busy[i])
      );
   end

   always_comb begin
      led_d = state;
`ifdef LED_BLINK_BANK_PWM_EN
      for (int i = 0; i < CHANNELS; i++) begin
         led_d[i] = state[i] && ((bright[i] == '1) || (pwm_q < bright[i]));
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) led_q <= '0;
      else     led_q <= led_d;
   end

   assign led = led_q;

endmodule
